// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: clocked, word-addressed instruction store.
// Fetch port: valid/ready request, registered response with 1-cycle latency,
// response held under back-pressure. Program-load port writes words in RUN.
// After reset an init FSM rewrites every word (index for the first INIT_LEN
// words, zero above) before fetches are accepted.
// Optional feature: define IMEM_FAULT_CNT_EN to build a saturating 8-bit
// counter of accepted out-of-range fetches on fault_cnt; otherwise fault_cnt
// is tied to zero.
module instruction_memory_sync #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned INIT_LEN = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              rsp_ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic [7:0]        fault_cnt
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_in_range;
  logic              prog_in_range;
  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  prog_idx;
  logic [IDX_W-1:0]  init_idx;
  logic [DATA_W-1:0] init_word;

  // Address decode, init pattern and the fetch handshake
  always_comb begin
    req_in_range  = 32'(req_addr) < DEPTH;
    prog_in_range = 32'(prog_addr) < DEPTH;
    // Out-of-range addresses are steered to word 0 so the array is never
    // indexed past its end; their data is discarded anyway.
    req_idx       = req_in_range  ? IDX_W'(req_addr)  : '0;
    prog_idx      = prog_in_range ? IDX_W'(prog_addr) : '0;
    init_idx      = IDX_W'(ptr);
    init_word     = (32'(ptr) < INIT_LEN) ? DATA_W'(ptr) : '0;
    req_ready     = (state == ST_RUN) && !prog_we && (!rsp_valid || rsp_ready);
    accept        = req_valid && req_ready;
  end

  // Array write port: init sweep during INIT, program loads during RUN
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_idx] <= init_word;
    end else if (prog_we && prog_in_range) begin
      mem[prog_idx] <= prog_data;
    end
  end

  // Init FSM plus registered fetch response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      ptr       <= '0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= req_in_range ? mem[req_idx] : '0;
            rsp_fault <= !req_in_range;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef IMEM_FAULT_CNT_EN
  logic [7:0] fault_q;

  // Saturating count of accepted out-of-range fetches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= '0;
    end else if (accept && !req_in_range && (fault_q != '1)) begin
      fault_q <= fault_q + 8'd1;
    end
  end

  // Counter drives the status port
  always_comb begin
    fault_cnt = fault_q;
  end
`else
  // Counter not built: status port reads zero
  always_comb begin
    fault_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync: two instances (DEPTH 256 and DEPTH 200)
// share one stimulus stream; a cycle model checks both every cycle and
// directed vectors pin hand-computed values.
module tb_instruction_memory_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        rsp_ready = 1'b1;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;

  logic        req_ready_a, rsp_valid_a, rsp_fault_a, busy_a;
  logic [15:0] rsp_data_a;
  logic [7:0]  fault_cnt_a;
  logic        req_ready_b, rsp_valid_b, rsp_fault_b, busy_b;
  logic [15:0] rsp_data_b;
  logic [7:0]  fault_cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  instruction_memory_sync #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(256), .INIT_LEN(31)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_fault(rsp_fault_a),
    .rsp_ready(rsp_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy_a), .fault_cnt(fault_cnt_a)
  );

  instruction_memory_sync #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(200), .INIT_LEN(31)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_fault(rsp_fault_b),
    .rsp_ready(rsp_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy_b), .fault_cnt(fault_cnt_b)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: cycles since reset release (the memory is being swept
  // while this is below the depth), the visible response, a fault count and
  // the expected memory image.
  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  logic [15:0] m_mem [2][256];
  int          m_cyc  [2] = '{0, 0};
  bit          m_vld  [2] = '{0, 0};
  logic [15:0] m_data [2] = '{16'h0, 16'h0};
  bit          m_flt  [2] = '{0, 0};
  int          m_fcnt [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    bit rdy;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cyc[k]  = 0;
        m_vld[k]  = 1'b0;
        m_data[k] = 16'h0;
        m_flt[k]  = 1'b0;
        m_fcnt[k] = 0;
      end else if (m_cyc[k] < dep(k)) begin
        m_mem[k][m_cyc[k]] = (m_cyc[k] < 31) ? 16'(m_cyc[k]) : 16'h0;
        m_cyc[k]++;
      end else begin
        rdy = !prog_we && (!m_vld[k] || rsp_ready);
        if (prog_we && (int'(prog_addr) < dep(k)))
          m_mem[k][prog_addr] = prog_data;
        if (req_valid && rdy) begin
          m_vld[k] = 1'b1;
          if (int'(req_addr) < dep(k)) begin
            m_data[k] = m_mem[k][req_addr];
            m_flt[k]  = 1'b0;
          end else begin
            m_data[k] = 16'h0;
            m_flt[k]  = 1'b1;
`ifdef IMEM_FAULT_CNT_EN
            if (m_fcnt[k] < 255) m_fcnt[k]++;
`endif
          end
        end else if (rsp_ready) begin
          m_vld[k] = 1'b0;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        bit   e_busy, e_rdy;
        string s;
        s      = (k == 0) ? "a" : "b";
        e_busy = m_cyc[k] < dep(k);
        e_rdy  = !e_busy && !prog_we && (!m_vld[k] || rsp_ready);
        cmp({"model_busy_", s},      32'((k == 0) ? busy_a      : busy_b),      32'(e_busy));
        cmp({"model_req_ready_", s}, 32'((k == 0) ? req_ready_a : req_ready_b), 32'(e_rdy));
        cmp({"model_rsp_valid_", s}, 32'((k == 0) ? rsp_valid_a : rsp_valid_b), 32'(m_vld[k]));
        cmp({"model_rsp_data_", s},  32'((k == 0) ? rsp_data_a  : rsp_data_b),  32'(m_data[k]));
        cmp({"model_rsp_fault_", s}, 32'((k == 0) ? rsp_fault_a : rsp_fault_b), 32'(m_flt[k]));
        cmp({"model_fault_cnt_", s}, 32'((k == 0) ? fault_cnt_a : fault_cnt_b), 32'(m_fcnt[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [7:0] a, output logic [15:0] da, output logic fa,
                       output logic [15:0] db, output logic fb);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    #2;
    n = 0;
    while (!(req_ready_a && req_ready_b) && n < 50) begin
      @(posedge clk);
      #4;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fetch_wait: req_ready low for 50 cycles, required high");
    end
    tick();
    req_valid = 1'b0;
    cmp("fetch_rsp_valid", 32'(rsp_valid_a), 32'd1);
    da = rsp_data_a;
    fa = rsp_fault_a;
    db = rsp_data_b;
    fb = rsp_fault_b;
  endtask

  task automatic wait_init(input string name, input int exp_a, input int exp_b);
    int na, nb;
    na = 0;
    nb = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy_a && !busy_b) break;
      if (busy_a) na++;
      if (busy_b) nb++;
      tick();
    end
    cmp({name, "_busy_cycles_a"}, 32'(na), 32'(exp_a));
    cmp({name, "_busy_cycles_b"}, 32'(nb), 32'(exp_b));
  endtask

  initial begin
    logic [15:0] da, db;
    logic        fa, fb;
    logic [7:0]  init_addr [5] = '{8'd0, 8'd5, 8'd30, 8'd31, 8'd255};
    logic [15:0] init_exp  [5] = '{16'd0, 16'd5, 16'd30, 16'd0, 16'd0};

    // reset
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    cmp("rst_busy", 32'(busy_a), 32'd1);
    cmp("rst_req_ready", 32'(req_ready_a), 32'd0);
    cmp("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    cmp("rst_rsp_data", 32'(rsp_data_a), 32'd0);
    cmp("rst_fault_cnt", 32'(fault_cnt_a), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_init("init", 256, 200);

    // init pattern
    for (int i = 0; i < 5; i++) begin
      fetch(init_addr[i], da, fa, db, fb);
      cmp($sformatf("init_data_%0d", init_addr[i]), 32'(da), 32'(init_exp[i]));
      cmp($sformatf("init_fault_%0d", init_addr[i]), 32'(fa), 32'd0);
    end

    // streaming
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp($sformatf("stream_valid_%0d", i), 32'(rsp_valid_a), 32'd1);
      cmp($sformatf("stream_data_%0d", i), 32'(rsp_data_a), 32'(i));
      if (i < 9) req_addr = 8'(i + 1);
    end

    // back-pressure
    req_addr = 8'd7;
    tick();
    rsp_ready = 1'b0;
    req_addr  = 8'd8;
    for (int j = 0; j < 3; j++) begin
      #2;
      cmp("bp_req_ready", 32'(req_ready_a), 32'd0);
      cmp("bp_hold_data", 32'(rsp_data_a), 32'd7);
      @(posedge clk);
      #2;
    end
    rsp_ready = 1'b1;
    #2;
    cmp("bp_release_ready", 32'(req_ready_a), 32'd1);
    tick();
    cmp("bp_next_data", 32'(rsp_data_a), 32'd8);
    req_valid = 1'b0;
    tick();

    // program write then fetch
    prog_we   = 1'b1;
    prog_addr = 8'd3;
    prog_data = 16'hBEEF;
    #2;
    cmp("prog_blocks_ready", 32'(req_ready_a), 32'd0);
    tick();
    prog_we = 1'b0;
    fetch(8'd3, da, fa, db, fb);
    cmp("prog_readback", 32'(da), 32'hBEEF);

    // simultaneous write and fetch: write wins, fetch retried
    prog_we   = 1'b1;
    prog_addr = 8'd4;
    prog_data = 16'h1234;
    req_valid = 1'b1;
    req_addr  = 8'd5;
    #2;
    cmp("race_req_ready", 32'(req_ready_a), 32'd0);
    tick();
    prog_we = 1'b0;
    #2;
    cmp("retry_req_ready", 32'(req_ready_a), 32'd1);
    tick();
    cmp("retry_data", 32'(rsp_data_a), 32'd5);
    req_valid = 1'b0;
    fetch(8'd4, da, fa, db, fb);
    cmp("race_write_data", 32'(da), 32'h1234);

    // out of range (only for the 200-word instance)
    fetch(8'd210, da, fa, db, fb);
    cmp("oor_data_a", 32'(da), 32'd0);
    cmp("oor_fault_a", 32'(fa), 32'd0);
    cmp("oor_data_b", 32'(db), 32'd0);
    cmp("oor_fault_b", 32'(fb), 32'd1);
    req_valid = 1'b1;
    req_addr  = 8'd210;
    repeat (300) tick();
    req_valid = 1'b0;
    tick();
`ifdef IMEM_FAULT_CNT_EN
    cmp("fault_cnt_sat_b", 32'(fault_cnt_b), 32'd255);
`else
    cmp("fault_cnt_off_b", 32'(fault_cnt_b), 32'd0);
`endif
    cmp("fault_cnt_a", 32'(fault_cnt_a), 32'd0);

    // mid-operation reset
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 8'd3;
    tick();
    req_valid = 1'b0;
    cmp("pre_rst_valid", 32'(rsp_valid_a), 32'd1);
    rst = 1'b1;
    #1;
    cmp("midrst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    cmp("midrst_busy", 32'(busy_a), 32'd1);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    wait_init("reinit", 256, 200);
    fetch(8'd3, da, fa, db, fb);
    cmp("reinit_data_a", 32'(da), 32'd3);
    cmp("reinit_data_b", 32'(db), 32'd3);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
